// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl: sequences a change payout one coin at a time, largest
// coin first. Coin types whose hopper reports empty, or that have faulted, are
// skipped. Any amount that cannot be paid is reported in o_remainder.
// Optional build macro: DISPENSE_TIMEOUT_EN. When it is defined, a hopper that
// does not accept a coin within TIMEOUT_CYCLES cycles is flagged in
// o_hopper_fault and excluded until reset.
module change_dispense_ctrl #(
  parameter int unsigned TOTAL_BITS     = 31,
  parameter int unsigned COIN0_VALUE    = 100,
  parameter int unsigned COIN1_VALUE    = 500,
  parameter int unsigned COIN2_VALUE    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [TOTAL_BITS-1:0] i_amount,
  input  logic [2:0]            i_coin_empty,
  output logic                  o_busy,
  output logic                  o_coin_valid,
  output logic [2:0]            o_coin_sel,
  input  logic                  i_coin_ready,
  output logic                  o_done,
  output logic [TOTAL_BITS-1:0] o_remainder,
  output logic [2:0]            o_hopper_fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_DISPENSE,
    S_DONE
  } state_e;

  localparam logic [TOTAL_BITS-1:0] COIN0_V = TOTAL_BITS'(COIN0_VALUE);
  localparam logic [TOTAL_BITS-1:0] COIN1_V = TOTAL_BITS'(COIN1_VALUE);
  localparam logic [TOTAL_BITS-1:0] COIN2_V = TOTAL_BITS'(COIN2_VALUE);

  state_e                  state_q, state_d;
  logic [TOTAL_BITS-1:0]   rem_q, rem_d;
  logic [TOTAL_BITS-1:0]   remainder_q, remainder_d;
  logic [2:0]              sel_q, sel_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [2:0]              fault_mask;
  logic [2:0]              coin_ok;
  logic [TOTAL_BITS-1:0]   disp_val;

`ifdef DISPENSE_TIMEOUT_EN
  localparam int unsigned  CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              fault_q, fault_d;

  assign fault_mask     = fault_q;
  assign o_hopper_fault = fault_q;
`else
  // The timeout length only matters in the timeout build; fold it into a
  // dangling net so the parameter stays in the interface.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign fault_mask     = '0;
  assign o_hopper_fault = '0;
`endif

  assign o_busy       = busy_q;
  assign o_coin_valid = valid_q;
  assign o_coin_sel   = sel_q;
  assign o_done       = done_q;
  assign o_remainder  = remainder_q;

  // Which coin types could be paid from the current remainder right now.
  always_comb begin
    coin_ok[0] = (rem_q >= COIN0_V) && !i_coin_empty[0] && !fault_mask[0];
    coin_ok[1] = (rem_q >= COIN1_V) && !i_coin_empty[1] && !fault_mask[1];
    coin_ok[2] = (rem_q >= COIN2_V) && !i_coin_empty[2] && !fault_mask[2];
  end

  // Value of the coin currently offered to the hopper (one-hot select).
  always_comb begin
    disp_val = ({TOTAL_BITS{sel_q[0]}} & COIN0_V)
             | ({TOTAL_BITS{sel_q[1]}} & COIN1_V)
             | ({TOTAL_BITS{sel_q[2]}} & COIN2_V);
  end

  // Next-state and registered-output logic; outputs are computed for the
  // state being entered so every output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    remainder_d = remainder_q;
    sel_d       = sel_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
    cnt_d       = cnt_q;
    fault_d     = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (i_start) begin
          rem_d       = i_amount;
          remainder_d = '0;
          busy_d      = 1'b1;
          state_d     = S_SELECT;
        end
      end
      S_SELECT: begin
        if (coin_ok != 3'b000) begin
          valid_d = 1'b1;
          state_d = S_DISPENSE;
          if (coin_ok[2])      sel_d = 3'b100;
          else if (coin_ok[1]) sel_d = 3'b010;
          else                 sel_d = 3'b001;
`ifdef DISPENSE_TIMEOUT_EN
          cnt_d = '0;
`endif
        end else begin
          // o_done and o_remainder are raised on entry so they are visible
          // during the single DONE cycle.
          done_d      = 1'b1;
          remainder_d = rem_q;
          state_d     = S_DONE;
        end
      end
      S_DISPENSE: begin
        if (i_coin_ready) begin
          rem_d   = rem_q - disp_val;
          valid_d = 1'b0;
          sel_d   = '0;
          state_d = S_SELECT;
        end
`ifdef DISPENSE_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          fault_d = fault_q | sel_q;
          valid_d = 1'b0;
          sel_d   = '0;
          state_d = S_SELECT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        sel_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Main state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      remainder_q <= '0;
      sel_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      remainder_q <= remainder_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef DISPENSE_TIMEOUT_EN
  // Hopper timeout counter and sticky fault flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      fault_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
`endif

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Testbench for change_dispense_ctrl: scoreboard fed by a greedy payout model,
// with an independent monitor checking coin handshakes and done pulses.
module tb_change_dispense_ctrl;

  logic        clk;
  logic        reset_n;
  logic        i_start;
  logic [30:0] i_amount;
  logic [2:0]  i_coin_empty;
  logic        o_busy;
  logic        o_coin_valid;
  logic [2:0]  o_coin_sel;
  logic        i_coin_ready;
  logic        o_done;
  logic [30:0] o_remainder;
  logic [2:0]  o_hopper_fault;

  change_dispense_ctrl #(
    .TOTAL_BITS    (31),
    .COIN0_VALUE   (100),
    .COIN1_VALUE   (500),
    .COIN2_VALUE   (1000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_start       (i_start),
    .i_amount      (i_amount),
    .i_coin_empty  (i_coin_empty),
    .o_busy        (o_busy),
    .o_coin_valid  (o_coin_valid),
    .o_coin_sel    (o_coin_sel),
    .i_coin_ready  (i_coin_ready),
    .o_done        (o_done),
    .o_remainder   (o_remainder),
    .o_hopper_fault(o_hopper_fault)
  );

  typedef struct {
    bit          is_done;
    logic [2:0]  sel;
    logic [30:0] rem;
  } exp_t;

  exp_t       sbq[$];
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  int         ready_mode = 0;
  logic [2:0] known_fault = 3'b000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Greedy payout reference: repeatedly take the largest usable coin.
  task automatic push_model(input logic [30:0] amt, input logic [2:0] excl);
    int unsigned r = amt;
    int unsigned vals [3] = '{100, 500, 1000};
    bit found = 1'b1;
    exp_t e;
    while (found) begin
      found = 1'b0;
      for (int j = 2; j >= 0; j--) begin
        if (!found && !excl[j] && r >= vals[j]) begin
          e.is_done = 1'b0;
          e.sel = 3'(1 << j);
          e.rem = '0;
          sbq.push_back(e);
          r -= vals[j];
          found = 1'b1;
        end
      end
    end
    e.is_done = 1'b1;
    e.sel = '0;
    e.rem = 31'(r);
    sbq.push_back(e);
  endtask

  task automatic start_txn(input logic [30:0] amt, input logic [2:0] emp);
    @(posedge clk); #1;
    i_amount = amt;
    i_coin_empty = emp;
    i_start = 1'b1;
    push_model(amt, emp | known_fault);
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", 32'(done_cnt != d0), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_valid"}, 32'(o_coin_valid), 0);
    check({tag, "_sel"}, 32'(o_coin_sel), 0);
    check({tag, "_done"}, 32'(o_done), 0);
    check({tag, "_remainder"}, 32'(o_remainder), 0);
    check({tag, "_fault"}, 32'(o_hopper_fault), 0);
  endtask

  // Hopper ready driver: always ready, random with bounded stalls, never,
  // or refuse only coin 2.
  initial begin
    int stall = 0;
    i_coin_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: i_coin_ready = 1'b1;
        1: i_coin_ready = (stall >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        2: i_coin_ready = 1'b0;
        default: i_coin_ready = !o_coin_sel[2];
      endcase
      stall = i_coin_ready ? 0 : stall + 1;
    end
  end

  // Monitor: pops the scoreboard on each accepted coin and each done pulse.
  initial begin
    logic       stall_prev = 1'b0;
    logic       done_prev = 1'b0;
    logic [2:0] sel_prev = '0;
    logic [2:0] fault_prev = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall_prev = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (stall_prev && o_hopper_fault == fault_prev) begin
          check("hold_valid", 32'(o_coin_valid), 1);
          check("hold_sel", 32'(o_coin_sel), 32'(sel_prev));
        end
        if (done_prev) begin
          check("busy_after_done", 32'(o_busy), 0);
          check("done_one_cycle", 32'(o_done), 0);
        end
        if (o_coin_valid && i_coin_ready) begin
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL coin_unexpected: got sel %b expected no coin", o_coin_sel);
          end else begin
            e = sbq.pop_front();
            check("coin_sel", 32'(o_coin_sel), e.is_done ? 32'd0 : 32'(e.sel));
          end
        end
        if (o_done) begin
          done_cnt++;
          check("busy_in_done", 32'(o_busy), 1);
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL done_unexpected: got done expected nothing");
          end else begin
            e = sbq.pop_front();
            if (!e.is_done) begin
              total++; bad++;
              $display("FAIL done_early: got done expected coin sel %b", e.sel);
            end else begin
              check("remainder", 32'(o_remainder), 32'(e.rem));
            end
          end
        end
        stall_prev = o_coin_valid && !i_coin_ready;
        sel_prev = o_coin_sel;
        fault_prev = o_hopper_fault;
        done_prev = o_done;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int d0;
    int n;
    reset_n = 1'b0;
    i_start = 1'b0;
    i_amount = '0;
    i_coin_empty = '0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    reset_n = 1'b1;

    // 1600 with all hoppers full: 1000, 500, 100.
    ready_mode = 0;
    d0 = done_cnt;
    start_txn(31'd1600, 3'b000);
    check("start_busy", 32'(o_busy), 1);
    check("start_valid_low", 32'(o_coin_valid), 0);
    @(posedge clk); #1;
    check("first_valid_latency", 32'(o_coin_valid), 1);
    check("first_sel", 32'(o_coin_sel), 32'b100);
    wait_done(d0);

    // 250: two coin0, remainder 50.
    d0 = done_cnt;
    start_txn(31'd250, 3'b000);
    wait_done(d0);

    // coin2 empty, 2000: four coin1.
    d0 = done_cnt;
    start_txn(31'd2000, 3'b100);
    wait_done(d0);

    // All empty: done two edges after start, remainder 2000.
    d0 = done_cnt;
    start_txn(31'd2000, 3'b111);
    @(posedge clk); #1;
    check("empty_done_latency", 32'(o_done), 1);
    check("empty_no_valid", 32'(o_coin_valid), 0);
    check("empty_remainder", 32'(o_remainder), 2000);
    wait_done(d0);

    // Zero amount: done two edges after start, remainder 0.
    d0 = done_cnt;
    start_txn(31'd0, 3'b000);
    @(posedge clk); #1;
    check("zero_done_latency", 32'(o_done), 1);
    wait_done(d0);

    // Ready held low for five cycles on the first coin; a second start is ignored.
    ready_mode = 2;
    d0 = done_cnt;
    start_txn(31'd1500, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(o_coin_valid), 1);
      check("stall_sel", 32'(o_coin_sel), 32'b100);
      if (i == 1) begin
        i_start = 1'b1;
        i_amount = 31'd100;
      end
      if (i == 2) i_start = 1'b0;
    end
    #1;
    ready_mode = 0;
    wait_done(d0);

    // Reset in DISPENSE clears everything at once; next payout works normally.
    ready_mode = 2;
    start_txn(31'd1500, 3'b000);
    n = 0;
    while (!o_coin_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("reset_test_valid", 32'(o_coin_valid), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    sbq.delete();
    @(posedge clk); #2;
    reset_n = 1'b1;
    ready_mode = 0;
    d0 = done_cnt;
    start_txn(31'd500, 3'b000);
    wait_done(d0);

    // Randomised payouts with random empty masks and bounded ready stalls.
    ready_mode = 1;
    for (int t = 0; t < 40; t++) begin
      d0 = done_cnt;
      start_txn(31'($urandom_range(0, 4000)), 3'($urandom_range(0, 7)));
      wait_done(d0);
    end

`ifdef DISPENSE_TIMEOUT_EN
    // Coin 2 hopper never accepts: fault after 8 cycles, then two coin1.
    ready_mode = 3;
    known_fault = 3'b100;
    d0 = done_cnt;
    start_txn(31'd1000, 3'b000);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_coin_valid && o_coin_sel == 3'b100) n++;
      if (o_hopper_fault != 3'b000) break;
    end
    check("timeout_cycles", 32'(n), 8);
    check("fault_flag", 32'(o_hopper_fault), 32'b100);
    wait_done(d0);
`endif

    check("scoreboard_empty", 32'(sbq.size()), 0);
    check("final_fault", 32'(o_hopper_fault), 32'(known_fault));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
